// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PEND_PRESS,
    PRESSED,
    PEND_RELEASE
  } key_state_e;

  typedef struct packed {
    logic       none;
    logic [3:0] code;
  } key_scan_t;

  // Indexed [row][col]; rows top-down, columns left-right.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  function automatic logic [2:0] count_low(input logic [3:0] rows_n);
    count_low = '0;
    for (int i = 0; i < 4; i++) count_low = count_low + {2'b00, ~rows_n[i]};
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] rows_n);
    first_low = '0;
    for (int i = 3; i >= 0; i--) if (!rows_n[i]) first_low = 2'(i);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM driven once per full keypad scan.
// Defining KEYPAD_REPEAT_EN adds an auto-repeat counter while a key is held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 50
`endif
) (
  input  logic      clk,
  input  logic      n_rst,
  input  logic      scan_done,
  input  key_scan_t scan,
  output logic [3:0] key_code,
  output logic      key_valid,
  output logic      key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d, code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d;
  logic          match_cand, match_code, one_scan;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    cnt_inc    = cnt_q + CW'(1);
    one_scan   = (DEBOUNCE_SCANS == 1);
    match_cand = !scan.none && (scan.code == cand_q);
    match_code = !scan.none && (scan.code == code_q);
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
`endif

    if (scan_done) begin
      case (state_q)
        RELEASED: begin
          if (!scan.none) begin
            cand_d = scan.code;
            cnt_d  = CW'(1);
            if (one_scan) begin
              state_d = PRESSED;
              code_d  = scan.code;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = PEND_PRESS;
            end
          end
        end
        PEND_PRESS: begin
          if (match_cand) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (scan.none) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cand_d = scan.code;
            cnt_d  = CW'(1);
          end
        end
        PRESSED: begin
          if (!match_code) begin
            if (one_scan) begin
              state_d = RELEASED;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = PEND_RELEASE;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_RELEASE: begin
          if (match_code) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
            state_d = RELEASED;
            held_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = RELEASED;
      endcase

`ifdef KEYPAD_REPEAT_EN
      // Only scans spent entirely inside PRESSED advance the repeat count.
      if (state_q == PRESSED && state_d == PRESSED) begin
        rep_d = rep_q + RW'(1);
        if (rep_d == RW'(REPEAT_SCANS)) begin
          valid_d = 1'b1;
          rep_d   = '0;
        end
      end else begin
        rep_d = '0;
      end
`endif
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling and per-scan key result.
// Defining KEYPAD_REPEAT_EN enables auto-repeat in the debounce stage.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 50
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = $clog2(SCAN_CYCLES);

  logic [3:0]    row_sync1_q, row_sync2_q;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    hit_code_q, hit_code_d;
  key_scan_t     scan_q, scan_d;
  logic          scan_done_q, scan_done_d;
  logic          sample;
  logic [2:0]    col_hits, hit_total;
  logic [1:0]    hits_sum;
  logic [3:0]    code_sel;

  assign col_n = ~(4'b0001 << col_idx_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_sync1_q <= 4'hF;
      row_sync2_q <= 4'hF;
      per_cnt_q   <= '0;
      col_idx_q   <= '0;
      hits_q      <= '0;
      hit_code_q  <= '0;
      scan_q      <= '{none: 1'b1, code: 4'h0};
      scan_done_q <= 1'b0;
    end else begin
      row_sync1_q <= row_n;
      row_sync2_q <= row_sync1_q;
      per_cnt_q   <= per_cnt_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      hit_code_q  <= hit_code_d;
      scan_q      <= scan_d;
      scan_done_q <= scan_done_d;
    end
  end

  // Hit count saturates at 2, so any multi-key scan collapses to NONE.
  always_comb begin
    sample      = (per_cnt_q == PW'(SCAN_CYCLES - 1));
    col_hits    = count_low(row_sync2_q);
    hit_total   = {1'b0, hits_q} + col_hits;
    hits_sum    = (hit_total > 3'd1) ? 2'd2 : hit_total[1:0];
    code_sel    = (col_hits == 3'd1) ? KEY_MAP[first_low(row_sync2_q)][col_idx_q] : hit_code_q;
    per_cnt_d   = per_cnt_q + PW'(1);
    col_idx_d   = col_idx_q;
    hits_d      = hits_q;
    hit_code_d  = hit_code_q;
    scan_d      = scan_q;
    scan_done_d = 1'b0;

    if (sample) begin
      per_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (col_idx_q == 2'd3) begin
        scan_done_d = 1'b1;
        scan_d.none = (hits_sum != 2'd1);
        scan_d.code = code_sel;
        hits_d      = '0;
        hit_code_d  = '0;
      end else begin
        hits_d     = hits_sum;
        hit_code_d = code_sel;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_SCANS(REPEAT_SCANS)
`endif
  ) u_debounce (
    .clk      (clk),
    .n_rst    (n_rst),
    .scan_done(scan_done_q),
    .scan     (scan_q),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded random/directed bench for keypad_scanner with a keypad matrix model.
// Build with KEYPAD_REPEAT_EN defined to exercise auto-repeat.
module tb_keypad_scanner;

  localparam int SC        = 8;
  localparam int DB        = 3;
  localparam int SCAN_CLKS = 4 * SC;
`ifdef KEYPAD_REPEAT_EN
  localparam int RS        = 4;
`endif

  localparam logic [3:0] KEY_OF [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef struct {
    logic [3:0] code;
    int         scan;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, key_held;
  logic [15:0] press_mask = '0;
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt;
  bit          col_chk_en = 1'b0;
  bit          prev_valid = 1'b0;
  exp_t        exp_q[$];

  bit          m_pressed;
  logic [3:0]  m_key, m_last;
  int          m_run, m_miss, m_rep, scan_idx;

  keypad_scanner #(
    .SCAN_CYCLES(SC),
    .DEBOUNCE_SCANS(DB)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_SCANS(RS)
`endif
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to a column that is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input bit exp_held, input logic [3:0] exp_code);
    checkVal("key_held", {3'b000, key_held}, {3'b000, exp_held});
    checkVal("key_code", key_code, exp_code);
  endtask

  // Reference: a key is accepted after DB identical single-key scans while released,
  // and released after DB scans that do not show it.
  task automatic modelScan(input logic [15:0] mask);
    bit         res_none;
    logic [3:0] res_code;
    res_none = ($countones(mask) != 1);
    res_code = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) res_code = KEY_OF[i];
    if (!m_pressed) begin
      if (res_none)                          m_run = 0;
      else if (m_run > 0 && res_code == m_last) m_run++;
      else                                   m_run = 1;
      m_last = res_code;
      if (m_run == DB) begin
        m_pressed = 1'b1;
        m_key     = res_code;
        m_miss    = 0;
        m_rep     = 0;
        exp_q.push_back('{code: res_code, scan: scan_idx});
      end
    end else if (!res_none && res_code == m_key) begin
      if (m_miss > 0) begin
        m_miss = 0;
        m_rep  = 0;
      end else begin
`ifdef KEYPAD_REPEAT_EN
        m_rep++;
        if (m_rep == RS) begin
          m_rep = 0;
          exp_q.push_back('{code: m_key, scan: scan_idx});
        end
`endif
      end
    end else begin
      m_rep = 0;
      m_miss++;
      if (m_miss == DB) begin
        m_pressed = 1'b0;
        m_run     = 0;
      end
    end
    scan_idx++;
  endtask

  // One full scan with a fixed key mask, starting exactly on a scan boundary.
  task automatic applyStimulus(input logic [15:0] mask);
    bit         exp_held;
    logic [3:0] exp_code;
    press_mask = mask;
    exp_held   = m_pressed;
    exp_code   = m_key;
    modelScan(mask);
    repeat (SCAN_CLKS / 2) @(posedge clk);
    @(negedge clk);
    checkOutput(exp_held, exp_code);
    repeat (SCAN_CLKS / 2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic holdScans(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) applyStimulus(mask);
  endtask

  task automatic checkDrained(input string name);
    repeat (4) @(negedge clk);
    checkVal(name, 4'(exp_q.size()), 4'h0);
  endtask

  task automatic doReset();
    n_rst = 1'b0;
    #1;
    checkVal("rst_col_n", col_n, 4'b1110);
    checkVal("rst_key_code", key_code, 4'h0);
    checkVal("rst_key_valid", {3'b000, key_valid}, 4'h0);
    checkVal("rst_key_held", {3'b000, key_held}, 4'h0);
    exp_q.delete();
    m_pressed = 1'b0;
    m_key     = 4'h0;
    m_last    = 4'h0;
    m_run     = 0;
    m_miss    = 0;
    m_rep     = 0;
    scan_idx  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Scoreboard monitor: every key_valid pulse must match the oldest expected press.
  always @(negedge clk) begin
    exp_t e;
    int   lo;
    if (n_rst && key_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("[TB] FAIL valid_gap actual=back-to-back expected=isolated (t=%0t)", $time);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse actual=code %h expected=no pulse (t=%0t)", key_code, $time);
      end else begin
        e  = exp_q.pop_front();
        lo = SCAN_CLKS * (e.scan + 1);
        checkVal("pulse_code", key_code, e.code);
        checks++;
        if (edge_cnt < lo || edge_cnt > lo + 4) begin
          errors++;
          $display("[TB] FAIL pulse_time actual=%0d expected=%0d..%0d", edge_cnt, lo, lo + 4);
        end
      end
    end
    prev_valid = n_rst && key_valid;
  end

  always @(negedge clk) begin
    logic [3:0] one;
    one = 4'b0001;
    if (col_chk_en) checkVal("col_n", col_n, ~(one << ((edge_cnt / SC) % 4)));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rmask;
    #2;
    doReset();

    col_chk_en = 1'b1;
    holdScans(16'h0000, 2);
    col_chk_en = 1'b0;
    holdScans(16'h0000, 14);

    holdScans(16'h0020, 6);
    holdScans(16'h0000, 5);

    applyStimulus(16'h0400);
    applyStimulus(16'h0000);
    holdScans(16'h0400, 5);
    holdScans(16'h0000, 4);

    holdScans(16'h8001, 5);
    holdScans(16'h0001, 5);
    holdScans(16'h0000, 4);

    holdScans(16'h0008, 4);
    checkDrained("drain_before_reset");
    @(posedge clk);
    #2;
    doReset();
    holdScans(16'h0008, 5);
    holdScans(16'h0000, 4);

    rmask = '0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) >= 7) begin
        case ($urandom_range(0, 9))
          0, 1, 2:       rmask = '0;
          3, 4, 5, 6, 7: rmask = 16'(1) << $urandom_range(0, 15);
          default:       rmask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      applyStimulus(rmask);
    end
    holdScans(16'h0000, 4);

    holdScans(16'h2000, 20);
    holdScans(16'h0000, 4);

    checkDrained("drain_final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
